ctrl_semaforo: RTL and testbench
================================

// Module: ctrl_semaforo
// PURPOSE
//  Sequences the 4-phase traffic-light cycle and runs its 2-digit BCD countdown.
//  - Holds the phase register (estado), the special-case flag (casoEsp) and the tens/units countdown.
//  - Loads the per-phase preset on every phase change.
//  - The phase decoder and the 7-segment display driver sit downstream and consume estado, dez and unid.
// PARAMETERS
//  none; the preset table is fixed, see BEHAVIOUR.
// PORTS
//  clk          in   1  system clock; all state updates on rising edge
//  rst          in   1  asynchronous, active-high reset
//  tick         in   1  1-cycle enable pulse; one countdown step per pulse (1 Hz nominal)
//  pedido       in   1  special-case request; level or pulse, latched internally
//  estado       out  2  current phase 00->01->10->11->00
//  casoEsp      out  1  special-case timing active for the current cycle
//  unid         out  4  countdown units digit, BCD 0-9
//  dez          out  2  countdown tens digit, 0-3
//  fim_fase     out  1  1-cycle pulse in the cycle a phase ends (registered)
// BEHAVIOUR
//  Preset table, written as estado,casoEsp -> dez unid:
//   00,0 -> 1 0 | 01,0 -> 1 5 | 10,0 -> 3 0 | 11,0 -> 0 5
//   00,1 -> 1 0 | 01,1 -> 2 2 | 10,1 -> 1 5 | 11,1 -> 0 5
//  Reset (async, rst=1):
//   - estado=00, casoEsp=0, pendente=0, dez=1, unid=0, fim_fase=0.
//   - Count is held while rst=1; the first tick after release decrements.
//  tick=0: all state holds, except that pendente can still be set.
//  tick=1 and {dez,unid}!=00: BCD decrement.
//   - unid>0: unid-1.
//   - unid==0: unid=9 and dez-1.
//   - Result is visible on the next clock edge.
//  tick=1 and {dez,unid}==00: phase end.
//   - estado <= estado+1, wrapping 11 -> 00.
//   - Count loaded with preset(new estado, casoEsp after update).
//   - fim_fase=1 for exactly that one cycle.
//   - A phase therefore lasts preset+1 ticks.
//  casoEsp: updated only on the 11->00 transition.
//   - casoEsp <= pendente | pedido; pendente <= 0 on the same edge.
//   - It stays constant through phases 00..11 of one cycle.
//  pendente: set by pedido=1 on any edge except the 11->00 edge, where pedido is consumed directly.
//   - Repeated requests within one cycle collapse into one.
//  Simultaneous pedido and 11->00 end: the request applies to the cycle now starting (casoEsp=1).
//  The count never underflows and never leaves BCD range.
//   - Non-BCD values are unreachable; if one is forced, the next tick loads unid=9 per the rule above.
//  Reset mid-phase: immediate return to reset values; pending requests are lost.
// CONFIGURATION
//  PAUSA_EN defined: adds input `pausa` (1 bit).
//   - While pausa=1, tick is ignored: count, estado and casoEsp are frozen and fim_fase=0.
//   - pedido is still latched into pendente.
//   - Releasing pausa resumes from the held count; no tick is lost or replayed.
//  PAUSA_EN undefined: no `pausa` port; tick always acts.
// TESTING
//  1. Reset, then 11 ticks -> count 10,09,..,00, then estado=01, count=15, fim_fase pulses once.
//  2. No pedido, run a full cycle -> phase lengths 11,16,31,6 ticks; estado returns to 00, casoEsp=0.
//  3. pedido pulse during phase 01, then finish the cycle -> casoEsp=1 from 00.
//     - Phase 01 loads 22 and phase 10 loads 15.
//     - Next cycle without pedido -> casoEsp=0.
//  4. pedido=1 in the same cycle as the 11->00 tick -> casoEsp=1 immediately; pendente=0 afterwards.
//  5. rst asserted asynchronously mid-phase 10, count 17 -> outputs 00/0/1 0 without a clock edge.
//  6. PAUSA_EN: pausa=1 at count 07 for 5 ticks -> count stays 07.
//     - After release, the next tick gives 06.
//     - pedido during the pause is latched.

Source files
------------

// File: rtl/ctrl_semaforo.sv
// ctrl_semaforo
//   Sequences the 4-phase traffic-light cycle (estado 00->01->10->11->00) and
//   runs the 2-digit BCD countdown of the current phase. The count is loaded
//   with the phase preset on every phase change. The special-case timing flag
//   (casoEsp) is chosen once per cycle, at the 11->00 transition, from any
//   request seen during the previous cycle.
//
// Ports
//   clk      in  1  system clock, rising edge
//   rst      in  1  asynchronous active-high reset
//   tick     in  1  one countdown step per pulse
//   pedido   in  1  special-case request (level or pulse, latched)
//   pausa    in  1  freezes the sequencer while high (only with PAUSA_EN)
//   estado   out 2  current phase
//   casoEsp  out 1  special-case timing active for this cycle
//   unid     out 4  countdown units digit, BCD 0-9
//   dez      out 2  countdown tens digit, 0-3
//   fim_fase out 1  registered 1-cycle pulse when a phase ends
//
// Configuration
//   PAUSA_EN  when defined, adds the pausa input; tick is ignored while
//             pausa=1 but requests are still latched.

module ctrl_semaforo (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       pedido,
`ifdef PAUSA_EN
    input  logic       pausa,
`endif
    output logic [1:0] estado,
    output logic       casoEsp,
    output logic [3:0] unid,
    output logic [1:0] dez,
    output logic       fim_fase
);

    typedef enum logic [1:0] {
        FASE_0 = 2'b00,
        FASE_1 = 2'b01,
        FASE_2 = 2'b10,
        FASE_3 = 2'b11
    } fase_t;

    fase_t      estado_q, estado_d;
    logic       caso_q,   caso_d;
    logic       pend_q,   pend_d;
    logic [1:0] dez_q,    dez_d;
    logic [3:0] unid_q,   unid_d;
    logic       fim_q,    fim_d;

    logic       passo;
    logic       contagem_zero;

    // Effective countdown step: a paused sequencer behaves as if no tick came.
`ifdef PAUSA_EN
    assign passo = tick & ~pausa;
`else
    assign passo = tick;
`endif

    assign contagem_zero = (dez_q == 2'd0) && (unid_q == 4'd0);

    // Preset table, returned as {dez, unid}.
    function automatic logic [5:0] preset(input fase_t fase, input logic esp);
        logic [5:0] val;
        val = {2'd1, 4'd0};
        case (fase)
            FASE_0: val = {2'd1, 4'd0};
            FASE_1: val = esp ? {2'd2, 4'd2} : {2'd1, 4'd5};
            FASE_2: val = esp ? {2'd1, 4'd5} : {2'd3, 4'd0};
            FASE_3: val = {2'd0, 4'd5};
            default: val = {2'd1, 4'd0};
        endcase
        return val;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q <= FASE_0;
            caso_q   <= 1'b0;
            pend_q   <= 1'b0;
            dez_q    <= 2'd1;
            unid_q   <= 4'd0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            caso_q   <= caso_d;
            pend_q   <= pend_d;
            dez_q    <= dez_d;
            unid_q   <= unid_d;
            fim_q    <= fim_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        caso_d   = caso_q;
        // Requests accumulate on every edge; only the cycle wrap consumes them.
        pend_d   = pend_q | pedido;
        dez_d    = dez_q;
        unid_d   = unid_q;
        fim_d    = 1'b0;

        if (passo) begin
            if (contagem_zero) begin
                estado_d = fase_t'(estado_q + 2'd1);
                fim_d    = 1'b1;
                // A request arriving on the wrap edge itself goes straight into
                // the cycle that is starting instead of waiting a whole cycle.
                if (estado_q == FASE_3) begin
                    caso_d = pend_q | pedido;
                    pend_d = 1'b0;
                end
                {dez_d, unid_d} = preset(estado_d, caso_d);
            end else if (unid_q == 4'd0) begin
                unid_d = 4'd9;
                dez_d  = dez_q - 2'd1;
            end else if (unid_q > 4'd9) begin
                // Out-of-range units digit: pull it back into BCD range
                // without touching the tens digit, so dez cannot wrap.
                unid_d = 4'd9;
            end else begin
                unid_d = unid_q - 4'd1;
            end
        end
    end

    assign estado   = estado_q;
    assign casoEsp  = caso_q;
    assign dez      = dez_q;
    assign unid     = unid_q;
    assign fim_fase = fim_q;

endmodule

// File: tb/tb_ctrl_semaforo.sv
module tb_ctrl_semaforo;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       pedido;
`ifdef PAUSA_EN
    logic       pausa;
`endif
    logic [1:0] estado;
    logic       casoEsp;
    logic [3:0] unid;
    logic [1:0] dez;
    logic       fim_fase;

    ctrl_semaforo dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .pedido   (pedido),
`ifdef PAUSA_EN
        .pausa    (pausa),
`endif
        .estado   (estado),
        .casoEsp  (casoEsp),
        .unid     (unid),
        .dez      (dez),
        .fim_fase (fim_fase)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remaining count held as a plain integer.
    int PRE_NRM[4] = '{10, 15, 30, 5};
    int PRE_ESP[4] = '{10, 22, 15, 5};
    int m_est, m_caso, m_pend, m_cnt, m_fim;

    logic [9:0] sb[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pack(input int e, input int c, input int cnt, input int f);
        logic [1:0] e2;
        logic       c1;
        logic [1:0] d2;
        logic [3:0] u4;
        logic       f1;
        e2 = e[1:0];
        c1 = c[0];
        d2 = 2'(cnt / 10);
        u4 = 4'(cnt % 10);
        f1 = f[0];
        return {e2, c1, d2, u4, f1};
    endfunction

    function automatic logic [9:0] observed();
        return {estado, casoEsp, dez, unid, fim_fase};
    endfunction

    task automatic model_reset();
        m_est = 0; m_caso = 0; m_pend = 0; m_cnt = 10; m_fim = 0;
    endtask

    task automatic model_step(input bit act, input bit p);
        m_fim = 0;
        if (act && m_cnt == 0) begin
            m_est = (m_est + 1) % 4;
            m_fim = 1;
            if (m_est == 0) begin
                m_caso = m_pend | p;
                m_pend = 0;
            end else begin
                m_pend = m_pend | p;
            end
            m_cnt = m_caso ? PRE_ESP[m_est] : PRE_NRM[m_est];
        end else begin
            m_pend = m_pend | p;
            if (act) m_cnt = m_cnt - 1;
        end
    endtask

    // One clock: drive at negedge, push expectation, compare after the edge.
    task automatic step(input bit t, input bit p, input bit pz);
        @(negedge clk);
        tick   = t;
        pedido = p;
`ifdef PAUSA_EN
        pausa  = pz;
        model_step(t && !pz, p);
`else
        model_step(t, p);
`endif
        sb.push_back(pack(m_est, m_caso, m_cnt, m_fim));
        @(posedge clk);
        #1;
        chk("step", observed(), sb.pop_front());
        tick   = 1'b0;
        pedido = 1'b0;
`ifdef PAUSA_EN
        pausa  = 1'b0;
`endif
    endtask

    // Tick until fim_fase is seen; pedido pulses on tick number ped_at.
    task automatic run_phase(input string tag, input int explen, input int ped_at, input bit idle);
        int n;
        n = 0;
        do begin
            step(1'b1, (n == ped_at), 1'b0);
            n++;
            if (!fim_fase && idle) step(1'b0, 1'b0, 1'b0);
        end while (!fim_fase && n < 40);
        chk(tag, n, explen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; pedido = 1'b0;
`ifdef PAUSA_EN
        pausa = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_hold", observed(), pack(0, 0, 10, 0));
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b0;

        // Full cycle without requests, with idle clocks between ticks.
        run_phase("t1_p0_len", 11, -1, 1'b1);
        chk("t1_after_p0", observed(), pack(1, 0, 15, 1));
        run_phase("t2_p1_len", 16, -1, 1'b1);
        run_phase("t2_p2_len", 31, -1, 1'b1);
        run_phase("t2_p3_len", 6, -1, 1'b1);
        chk("t2_caso", casoEsp, 0);

        // Request during phase 01 selects special timing for the next cycle.
        run_phase("t3a_p0_len", 11, -1, 1'b0);
        run_phase("t3a_p1_len", 16, 3, 1'b0);
        run_phase("t3a_p2_len", 31, -1, 1'b0);
        run_phase("t3a_p3_len", 6, -1, 1'b0);
        chk("t3_caso_on", casoEsp, 1);
        run_phase("t3b_p0_len", 11, -1, 1'b0);
        chk("t3_load22", observed(), pack(1, 1, 22, 1));
        run_phase("t3b_p1_len", 23, -1, 1'b0);
        chk("t3_load15", observed(), pack(2, 1, 15, 1));
        run_phase("t3b_p2_len", 16, -1, 1'b0);
        run_phase("t3b_p3_len", 6, -1, 1'b0);
        chk("t3_caso_off", casoEsp, 0);

        // Request on the very tick that wraps 11 -> 00.
        run_phase("t3c_p0_len", 11, -1, 1'b0);
        run_phase("t3c_p1_len", 16, -1, 1'b0);
        run_phase("t3c_p2_len", 31, -1, 1'b0);
        run_phase("t4_p3_len", 6, 5, 1'b0);
        chk("t4_caso_now", casoEsp, 1);
        run_phase("t4a_p0_len", 11, -1, 1'b0);
        run_phase("t4a_p1_len", 23, -1, 1'b0);
        run_phase("t4a_p2_len", 16, -1, 1'b0);
        run_phase("t4a_p3_len", 6, -1, 1'b0);
        chk("t4_pend_clear", casoEsp, 0);
        run_phase("t4b_p0_len", 11, -1, 1'b0);
        run_phase("t4b_p1_len", 16, -1, 1'b0);

        // Asynchronous reset mid-phase 10 at count 17, with a request pending.
        for (int i = 0; i < 13; i++) step(1'b1, (i == 2), 1'b0);
        chk("t5_pre", observed(), pack(2, 0, 17, 0));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async", observed(), pack(0, 0, 10, 0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_phase("t5_p0_len", 11, -1, 1'b0);
        run_phase("t5_p1_len", 16, -1, 1'b0);
        run_phase("t5_p2_len", 31, -1, 1'b0);
        run_phase("t5_p3_len", 6, -1, 1'b0);
        chk("t5_pend_lost", casoEsp, 0);

`ifdef PAUSA_EN
        // Pause at 07 for five ticks, with a request during the pause.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, (i == 1), 1'b1);
        chk("t6_held", observed(), pack(0, 0, 7, 0));
        step(1'b1, 1'b0, 1'b0);
        chk("t6_resume", observed(), pack(0, 0, 6, 0));
        run_phase("t6_p0_len", 7, -1, 1'b0);
        run_phase("t6_p1_len", 16, -1, 1'b0);
        run_phase("t6_p2_len", 31, -1, 1'b0);
        run_phase("t6_p3_len", 6, -1, 1'b0);
        chk("t6_caso", casoEsp, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
